// File: rtl/ser_pkg.sv
// ser_pkg: shared state type and default constants for the bit serializer
//   state_t       IDLE=1'b0, SHIFT=1'b1
//   DEF_WIDTH     default bits per word
//   DEF_IDLE_BIT  default level on x while no word is shifting
package ser_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    localparam int   DEF_WIDTH    = 64;
    localparam logic DEF_IDLE_BIT = 1'b0;
endpackage

// File: rtl/bit_serializer_if.sv
// bit_serializer_if: load handshake and serial output bundle of the bit serializer
//   load_valid/load_data/load_ready  word load port (valid/ready)
//   loop_stop                        present only when SER_LOOP_EN is defined
//   x/x_valid/bit_idx/word_done      serial output towards the detector
//   master: word source and bit consumer; slave: the serializer
interface bit_serializer_if #(
    parameter int WIDTH = ser_pkg::DEF_WIDTH
) ();
    localparam int CW = $clog2(WIDTH);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             x;
    logic             x_valid;
    logic [CW-1:0]    bit_idx;
    logic             word_done;
`ifdef SER_LOOP_EN
    logic             loop_stop;
    modport master (
        output load_valid, load_data, loop_stop,
        input  load_ready, x, x_valid, bit_idx, word_done
    );
    modport slave (
        input  load_valid, load_data, loop_stop,
        output load_ready, x, x_valid, bit_idx, word_done
    );
`else
    modport master (
        output load_valid, load_data,
        input  load_ready, x, x_valid, bit_idx, word_done
    );
    modport slave (
        input  load_valid, load_data,
        output load_ready, x, x_valid, bit_idx, word_done
    );
`endif
endinterface

// File: rtl/ser_bit_counter.sv
// ser_bit_counter: CW-bit down-counter that loads MAX and stops at zero
//   clk   clock
//   rst   synchronous active-low reset
//   load  load MAX (wins over dec)
//   dec   decrement, ignored once the count is zero
//   cnt   current count
//   last  cnt == 0
module ser_bit_counter #(
    parameter int            CW  = 6,
    parameter logic [CW-1:0] MAX = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          last
);
    // Zero is sticky without a load, so the count never wraps by itself.
    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= MAX;
        else if (dec && cnt != '0)
            cnt <= cnt - CW'(1);
    end
    assign last = cnt == '0;
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial bit source, MSB first, one bit per clk
//   clk  clock, rising edge
//   rst  synchronous active-low reset
//   bus  bit_serializer_if.slave:
//          load_valid/load_data/load_ready  word load handshake
//          x/x_valid/bit_idx                serial bit, qualifier, bit index
//          word_done                        one-cycle pulse after the last bit
//          loop_stop                        only with SER_LOOP_EN
//   SER_LOOP_EN: replay the last accepted word until loop_stop is seen at a word end
module bit_serializer #(
    parameter int   WIDTH    = ser_pkg::DEF_WIDTH,
    parameter logic IDLE_BIT = ser_pkg::DEF_IDLE_BIT
) (
    input logic             clk,
    input logic             rst,
    bit_serializer_if.slave bus
);
    import ser_pkg::*;
    localparam int CW = $clog2(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] reload_word;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             shifting;
    logic             accept;
    logic             reload;
    logic             word_done;
    assign shifting       = state == SHIFT;
    // A new word can be taken while the final bit of the current word is on x.
    assign bus.load_ready = !shifting || last;
    assign accept         = bus.load_valid && bus.load_ready;
`ifdef SER_LOOP_EN
    logic [WIDTH-1:0] copy;
    always_ff @(posedge clk) begin
        if (!rst)
            copy <= '0;
        else if (accept)
            copy <= bus.load_data;
    end
    // A fresh accept wins over replaying the stored word.
    assign reload      = shifting && last && !accept && !bus.loop_stop;
    assign reload_word = copy;
`else
    assign reload      = 1'b0;
    assign reload_word = '0;
`endif
    ser_bit_counter #(
        .CW (CW),
        .MAX(CW'(WIDTH - 1))
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .load(accept || reload),
        .dec (shifting),
        .cnt (cnt),
        .last(last)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= shifting && last;
            if (accept) begin
                state <= SHIFT;
                shreg <= bus.load_data;
            end else if (reload) begin
                shreg <= reload_word;
            end else begin
                if (last)
                    state <= IDLE;
                shreg <= shreg << 1;
            end
        end
    end
    assign bus.x         = shifting ? shreg[WIDTH-1] : IDLE_BIT;
    assign bus.x_valid   = shifting;
    assign bus.bit_idx   = shifting ? cnt : '0;
    assign bus.word_done = word_done;
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed scoreboard bench for bit_serializer (WIDTH 64 and WIDTH 4 instances)
module tb_bit_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(64)) b64 ();
    bit_serializer_if #(.WIDTH(4))  b4 ();

    bit_serializer #(.WIDTH(64), .IDLE_BIT(1'b0)) u64 (.clk(clk), .rst(rst), .bus(b64));
    bit_serializer #(.WIDTH(4),  .IDLE_BIT(1'b0)) u4  (.clk(clk), .rst(rst), .bus(b4));

    typedef struct packed {logic x; logic [7:0] idx;} exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] w);
        exp_t e;
        for (int i = 63; i >= 0; i--) begin
            e.x   = w[i];
            e.idx = 8'(i);
            q.push_back(e);
        end
    endtask

    // Every valid bit of the 64-bit instance is matched against the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (b64.x_valid === 1'b1) begin
            chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_x", 64'(b64.x), 64'(e.x));
                chk("sb_idx", 64'(b64.bit_idx), 64'(e.idx));
            end
        end
    end

    // Load one word into the 64-bit instance and follow it to its word_done pulse;
    // with poke set, a foreign word is offered mid-word and must be ignored.
    task automatic send64(input logic [63:0] w, input logic poke);
        @(negedge clk);
        b64.load_valid = 1'b1;
        b64.load_data  = w;
        push(w);
        @(negedge clk);
        b64.load_valid = 1'b0;
        for (int c = 1; c <= 65; c++) begin
            if (c > 1) @(negedge clk);
            if (poke && c == 10) begin
                chk("poke_ready", 64'(b64.load_ready), 64'd0);
                b64.load_valid = 1'b1;
                b64.load_data  = ~w;
            end
            if (poke && c == 11) begin
                b64.load_valid = 1'b0;
                b64.load_data  = w;
            end
            chk("w_done", 64'(b64.word_done), 64'(c == 65));
            chk("w_xvalid", 64'(b64.x_valid), 64'(c <= 64));
        end
        chk("w_drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic       found;
        logic [3:0] w4;
        b64.load_valid = 1'b0;
        b64.load_data  = '0;
        b4.load_valid  = 1'b0;
        b4.load_data   = '0;
`ifdef SER_LOOP_EN
        b64.loop_stop  = 1'b1;
        b4.loop_stop   = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk("rst_x", 64'(b64.x), 64'd0);
        chk("rst_xvalid", 64'(b64.x_valid), 64'd0);
        chk("rst_idx", 64'(b64.bit_idx), 64'd0);
        chk("rst_done", 64'(b64.word_done), 64'd0);
        chk("rst_ready", 64'(b64.load_ready), 64'd1);
        chk("rst_xvalid4", 64'(b4.x_valid), 64'd0);
        rst = 1'b1;

        // Test 1: single word right after reset release
        send64(64'h00EB_6939_52AE_6A6C, 1'b0);

        // Test 2: back-to-back words with load_valid held high
        @(negedge clk);
        b64.load_valid = 1'b1;
        b64.load_data  = '1;
        push('1);
        for (int c = 1; c <= 129; c++) begin
            @(negedge clk);
            if (c == 1) begin
                b64.load_data = '0;
                push('0);
            end
            if (c == 65) b64.load_valid = 1'b0;
            if (c <= 128) chk("b2b_ready", 64'(b64.load_ready), 64'(c == 64 || c == 128));
            chk("b2b_xvalid", 64'(b64.x_valid), 64'(c <= 128));
            chk("b2b_done", 64'(b64.word_done), 64'(c == 65 || c == 129));
        end
        chk("b2b_drained", 64'(q.size()), 64'd0);

        // Test 3: load pulse while mid-word is ignored
        send64(64'hA5C3_0F96_1234_8ECD, 1'b1);

        // Test 4: reset at bit_idx 40 abandons the word
        @(negedge clk);
        b64.load_valid = 1'b1;
        b64.load_data  = 64'h1357_9BDF_2468_ACE0;
        push(64'h1357_9BDF_2468_ACE0);
        @(negedge clk);
        b64.load_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (b64.x_valid === 1'b1 && b64.bit_idx === 6'd40) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_mid_seen", 64'(found), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        chk("rst_mid_x", 64'(b64.x), 64'd0);
        chk("rst_mid_xvalid", 64'(b64.x_valid), 64'd0);
        chk("rst_mid_idx", 64'(b64.bit_idx), 64'd0);
        chk("rst_mid_done", 64'(b64.word_done), 64'd0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b64.word_done !== 1'b0) found = 1'b1;
        end
        chk("rst_mid_nodone", 64'(found), 64'd0);
        send64(64'hC0FF_EE00_DEAD_BEEF, 1'b0);

        // Test 5: WIDTH=4 single word
        w4 = 4'b1011;
        @(negedge clk);
        b4.load_valid = 1'b1;
        b4.load_data  = w4;
        @(negedge clk);
        b4.load_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            chk("w4_x", 64'(b4.x), 64'(c <= 4 ? w4[4-c] : 1'b0));
            chk("w4_xvalid", 64'(b4.x_valid), 64'(c <= 4));
            chk("w4_ready", 64'(b4.load_ready), 64'(c >= 4));
            chk("w4_done", 64'(b4.word_done), 64'(c == 5));
        end

`ifdef SER_LOOP_EN
        // Test 6: looping replay stopped by loop_stop
        w4 = 4'b1001;
        b4.loop_stop = 1'b0;
        @(negedge clk);
        b4.load_valid = 1'b1;
        b4.load_data  = w4;
        @(negedge clk);
        b4.load_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 9) b4.loop_stop = 1'b1;
            chk("loop_x", 64'(b4.x), 64'(c <= 12 ? w4[3-((c-1)%4)] : 1'b0));
            chk("loop_xvalid", 64'(b4.x_valid), 64'(c <= 12));
            chk("loop_done", 64'(b4.word_done), 64'(c == 5 || c == 9 || c == 13));
        end
`endif

        @(negedge clk);
        chk("final_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
